uart_tx_queue: RTL and testbench

Transmit-side byte queue that sits directly upstream of the UART transmitter. Host logic pushes bytes at any rate into an internal FIFO. The queue then drains them one at a time into the transmitter, pulsing `EN` with a stable `DataIN` and waiting for the transmitter's frame-complete pulse before issuing the next byte. This decouples bursty producers from the fixed baud-rate serial line.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_queue.sv | 128 ++++++++++++
 tb/tb_uart_tx_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side queue.
package uart_pkg;

   localparam int DATA_W_DFLT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } tx_queue_state_t;

   // Width needed to hold the values 0..depth inclusive.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with separate occupancy counter; rejects pushes while full.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [DATA_W-1:0]         rd_data,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter: one EN strobe per byte, next byte after tx_done.
// Optional inter-frame idle gap enabled by defining UART_TX_QUEUE_GAP_EN.
//
// state | meaning
// IDLE  | nothing in flight; pops the head byte into DataIN when the queue is non-empty
// LOAD  | EN high for this single cycle
// WAIT  | transmitter busy with DataIN; waits for tx_done
// GAP   | counts GAP_TICKS baud ticks before allowing the next frame
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int DATA_W    = DATA_W_DFLT,
   parameter int GAP_TICKS = 2
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      ovf_clr,
   input  logic                      tx_done,
   input  logic                      BaudTick,
   output logic                      full,
   output logic                      empty,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      overflow,
   output logic                      busy,
   output logic                      EN,
   output logic [DATA_W-1:0]         DataIN
);

   tx_queue_state_t   state;
   tx_queue_state_t   state_nxt;
   logic              pop;
   logic [DATA_W-1:0] head;

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (Reset),
      .push    (wr_en),
      .pop     (pop),
      .wr_data (wr_data),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

`ifdef UART_TX_QUEUE_GAP_EN
   localparam int GW = count_w(GAP_TICKS);
   logic [GW-1:0] gap_cnt;
   logic          gap_tc;

   // Terminal count: the tick that brings the down-counter from 1 to 0 ends the gap.
   assign gap_tc = BaudTick && (gap_cnt <= GW'(1));

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         gap_cnt <= '0;
      end else if (state == WAIT && tx_done) begin
         gap_cnt <= GW'(GAP_TICKS);
      end else if (state == GAP && BaudTick && gap_cnt != '0) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end
`else
   localparam int unused_gap_ticks = GAP_TICKS;
   logic unused_baud;
   assign unused_baud = BaudTick;
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_nxt = LOAD;
               pop       = 1'b1;
            end
         end
         LOAD: state_nxt = WAIT;
         WAIT: begin
            if (tx_done) begin
`ifdef UART_TX_QUEUE_GAP_EN
               state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef UART_TX_QUEUE_GAP_EN
         GAP: begin
            if (gap_tc) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         DataIN <= '0;
      end else begin
         state <= state_nxt;
         if (pop) DataIN <= head;
      end
   end

   // A rejected push sets the flag even when a clear arrives in the same cycle.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign EN   = (state == LOAD);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (DEPTH=16, DATA_W=8, GAP_TICKS=2).
module tb_uart_tx_queue;

   logic       CLK;
   logic       Reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       ovf_clr;
   logic       tx_done;
   logic       BaudTick;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       busy;
   logic       EN;
   logic [7:0] DataIN;

   int total = 0;
   int bad   = 0;
   int en_seen;

   uart_tx_queue #(
      .DEPTH     (16),
      .DATA_W    (8),
      .GAP_TICKS (2)
   ) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .ovf_clr  (ovf_clr),
      .tx_done  (tx_done),
      .BaudTick (BaudTick),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .busy     (busy),
      .EN       (EN),
      .DataIN   (DataIN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // tx_done in cycle t: IDLE at t+1, next EN with byte exp at t+2.
   task automatic done_then_expect(input logic [7:0] exp, input logic [4:0] exp_cnt);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("gap_en_low", {31'd0, EN}, 32'd0);
      chk("gap_busy_low", {31'd0, busy}, 32'd0);
      step();
      chk("next_en", {31'd0, EN}, 32'd1);
      chk("next_data", {24'd0, DataIN}, {24'd0, exp});
      chk("next_count", {27'd0, count}, {27'd0, exp_cnt});
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin
      Reset    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      ovf_clr  = 1'b0;
      tx_done  = 1'b0;
      BaudTick = 1'b0;
      step();
      step();

      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_en", {31'd0, EN}, 32'd0);
      chk("rst_data", {24'd0, DataIN}, 32'd0);
      Reset = 1'b1;
      step();

      // Single byte.
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("sb_c1_empty", {31'd0, empty}, 32'd0);
      chk("sb_c1_count", {27'd0, count}, 32'd1);
      chk("sb_c1_en", {31'd0, EN}, 32'd0);
      step();
      chk("sb_c2_en", {31'd0, EN}, 32'd1);
      chk("sb_c2_data", {24'd0, DataIN}, 32'hA5);
      chk("sb_c2_count", {27'd0, count}, 32'd0);
      step();
      chk("sb_c3_en", {31'd0, EN}, 32'd0);
      chk("sb_c3_busy", {31'd0, busy}, 32'd1);
      tx_done = 1'b1;
      chk("sb_done_busy", {31'd0, busy}, 32'd1);
      step();
      tx_done = 1'b0;
      chk("sb_after_busy", {31'd0, busy}, 32'd0);
      chk("sb_hold_data", {24'd0, DataIN}, 32'hA5);
      en_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (EN) en_seen++;
         step();
      end
      chk("sb_no_extra_en", en_seen, 32'd0);

      // Burst 0x01..0x11: one byte is popped early, so the 17th push fills the queue.
      for (int i = 1; i <= 17; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         step();
         if (i == 2) begin
            chk("burst_first_en", {31'd0, EN}, 32'd1);
            chk("burst_first_data", {24'd0, DataIN}, 32'h01);
         end
         if (i == 16) chk("burst_not_full_16", {31'd0, full}, 32'd0);
      end
      chk("burst_full", {31'd0, full}, 32'd1);
      chk("burst_count", {27'd0, count}, 32'd16);

      // Overflow, then set-wins-over-clear, then clear.
      wr_data = 8'hFF;
      step();
      wr_en = 1'b0;
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {27'd0, count}, 32'd16);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);
      wr_en   = 1'b1;
      ovf_clr = 1'b1;
      step();
      wr_en   = 1'b0;
      ovf_clr = 1'b0;
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      chk("ovf_count2", {27'd0, count}, 32'd16);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr2", {31'd0, overflow}, 32'd0);
      chk("wait_still_busy", {31'd0, busy}, 32'd1);

      // Drain in order: the dropped 0xFF bytes must never appear.
      for (int k = 2; k <= 17; k++) begin
         done_then_expect(8'(k), 5'(17 - k));
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("drain_empty", {31'd0, empty}, 32'd1);
      chk("drain_idle", {31'd0, busy}, 32'd0);
      step();

      // Push exactly on the pop edge with three bytes queued.
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h30 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      chk("sim_count3", {27'd0, count}, 32'd3);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("sim_idle", {31'd0, busy}, 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'h34;
      step();
      wr_en = 1'b0;
      chk("sim_count_kept", {27'd0, count}, 32'd3);
      chk("sim_en", {31'd0, EN}, 32'd1);
      chk("sim_data", {24'd0, DataIN}, 32'h31);
      step();
      done_then_expect(8'h32, 5'd2);
      done_then_expect(8'h33, 5'd1);
      done_then_expect(8'h34, 5'd0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();

`ifdef UART_TX_QUEUE_GAP_EN
      // Two bytes; the second EN only after the second BaudTick following tx_done.
      for (int i = 0; i < 2; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h50 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (EN) en_seen++;
         step();
      end
      BaudTick = 1'b1;
      step();
      BaudTick = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (EN) en_seen++;
         step();
      end
      chk("gap_no_early_en", en_seen, 32'd0);
      BaudTick = 1'b1;
      step();
      BaudTick = 1'b0;
      chk("gap_tick2_en", {31'd0, EN}, 32'd0);
      step();
      chk("gap_en", {31'd0, EN}, 32'd1);
      chk("gap_data", {24'd0, DataIN}, 32'h51);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      BaudTick = 1'b1;
      step();
      step();
      BaudTick = 1'b0;
      step();
      chk("gap_done_idle", {31'd0, busy}, 32'd0);
`endif

      // Reset mid-frame in WAIT with five bytes queued.
      for (int i = 0; i < 6; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h60 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      chk("rw_count5", {27'd0, count}, 32'd5);
      chk("rw_busy", {31'd0, busy}, 32'd1);
      chk("rw_data", {24'd0, DataIN}, 32'h60);
      Reset = 1'b0;
      #1;
      chk("rw_count0", {27'd0, count}, 32'd0);
      chk("rw_en0", {31'd0, EN}, 32'd0);
      chk("rw_data0", {24'd0, DataIN}, 32'd0);
      chk("rw_busy0", {31'd0, busy}, 32'd0);
      chk("rw_empty", {31'd0, empty}, 32'd1);
      step();
      Reset = 1'b1;
      en_seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (EN) en_seen++;
      end
      chk("rw_no_en", en_seen, 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'h7E;
      step();
      wr_en = 1'b0;
      step();
      chk("rw_new_en", {31'd0, EN}, 32'd1);
      chk("rw_new_data", {24'd0, DataIN}, 32'h7E);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
